// File: rtl/cache_tag_lru.sv
// Tag store and true-LRU replacement unit for a 4-line fully-associative cache.
// Registers lookup/victim results every cycle and applies fill/dirty/touch commands on the clock edge.
module cache_tag_lru #(
    parameter int CACHE_SIZE = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] lookup_address,
    input  logic [CACHE_SIZE-1:0] line_select,
    input  logic                  cache_write_enable,
    input  logic                  set_valid_bit,
    input  logic                  set_dirty_bit,
    input  logic                  clear_dirty_bit,
    input  logic                  hit_signal,
    input  logic                  invalidate_all,
    output logic                  cache_hit,
    output logic [CACHE_SIZE-1:0] hit_lines,
    output logic [1:0]            hit_index,
    output logic [1:0]            replace_index,
    output logic                  replace_dirty,
    output logic [ADDR_WIDTH-1:0] replace_tag,
    output logic [CACHE_SIZE-1:0] valid_bits,
    output logic [CACHE_SIZE-1:0] dirty_bits,
    output logic                  sel_error
);

    logic [ADDR_WIDTH-1:0] r_tag [CACHE_SIZE];
    logic [1:0]            r_age [CACHE_SIZE];
    logic [CACHE_SIZE-1:0] r_valid;
    logic [CACHE_SIZE-1:0] r_dirty;

    logic                  r_cache_hit;
    logic [CACHE_SIZE-1:0] r_hit_lines;
    logic [1:0]            r_hit_index;
    logic [1:0]            r_replace_index;
    logic                  r_replace_dirty;
    logic [ADDR_WIDTH-1:0] r_replace_tag;
    logic                  r_sel_error;

    logic [CACHE_SIZE-1:0] w_match;
    logic [1:0]            w_hit_index;
    logic [1:0]            w_victim;
    logic                  w_has_invalid;
    logic                  w_legal;
    logic                  w_strobe;
    logic                  w_touch;
    logic [1:0]            w_k;

    always_comb begin
        w_match     = '0;
        w_hit_index = '0;
        for (int unsigned i = 0; i < CACHE_SIZE; i++)
            w_match[i] = r_valid[i] && (r_tag[i] == lookup_address);
        // Descending scan so the lowest matching index wins.
        for (int unsigned i = CACHE_SIZE; i > 0; i--)
            if (w_match[i-1]) w_hit_index = 2'(i-1);
    end

    always_comb begin
        w_has_invalid = 1'b0;
        w_victim      = '0;
        for (int unsigned i = CACHE_SIZE; i > 0; i--)
            if (r_age[i-1] == 2'd3) w_victim = 2'(i-1);
        for (int unsigned i = CACHE_SIZE; i > 0; i--)
            if (!r_valid[i-1]) begin
                w_has_invalid = 1'b1;
                w_victim      = 2'(i-1);
            end
    end

    always_comb begin
        w_k = '0;
        for (int unsigned i = 0; i < CACHE_SIZE; i++)
            if (line_select[i]) w_k = 2'(i);
    end

    assign w_legal  = (line_select != '0) && ((line_select & (line_select - 1'b1)) == '0);
    assign w_strobe = cache_write_enable | hit_signal | set_dirty_bit | clear_dirty_bit;
    assign w_touch  = (hit_signal | cache_write_enable) & w_legal & ~invalidate_all;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < CACHE_SIZE; i++) begin
                r_tag[i] <= '0;
                r_age[i] <= 2'(i);
            end
            r_valid         <= '0;
            r_dirty         <= '0;
            r_cache_hit     <= 1'b0;
            r_hit_lines     <= '0;
            r_hit_index     <= '0;
            r_replace_index <= '0;
            r_replace_dirty <= 1'b0;
            r_replace_tag   <= '0;
            r_sel_error     <= 1'b0;
        end else begin
            r_hit_lines     <= w_match;
            r_cache_hit     <= |w_match;
            r_hit_index     <= w_hit_index;
            r_replace_index <= w_victim;
            r_replace_dirty <= r_dirty[w_victim];
            r_replace_tag   <= r_tag[w_victim];

            if (w_strobe && !w_legal)
                r_sel_error <= 1'b1;

            if (invalidate_all) begin
                r_valid <= '0;
                r_dirty <= '0;
            end else if (cache_write_enable && w_legal) begin
                if (set_valid_bit) begin
                    r_tag[w_k]   <= lookup_address;
                    r_valid[w_k] <= 1'b1;
                    r_dirty[w_k] <= set_dirty_bit;
                end else if (set_dirty_bit) begin
                    r_dirty[w_k] <= 1'b1;
                end else if (clear_dirty_bit) begin
                    r_dirty[w_k] <= 1'b0;
                end
            end

            // Promote line k to MRU; only lines younger than it age, keeping a permutation.
            if (w_touch) begin
                for (int unsigned i = 0; i < CACHE_SIZE; i++) begin
                    if (2'(i) == w_k)
                        r_age[i] <= 2'd0;
                    else if (r_age[i] < r_age[w_k])
                        r_age[i] <= r_age[i] + 2'd1;
                end
            end
        end
    end

    assign cache_hit     = r_cache_hit;
    assign hit_lines     = r_hit_lines;
    assign hit_index     = r_hit_index;
    assign replace_index = r_replace_index;
    assign replace_dirty = r_replace_dirty;
    assign replace_tag   = r_replace_tag;
    assign valid_bits    = r_valid;
    assign dirty_bits    = r_dirty;
    assign sel_error     = r_sel_error;

endmodule

// File: tb/tb_cache_tag_lru.sv
// Directed-vector bench for cache_tag_lru: fills, LRU touches, dirty handling, select errors, flush and reset.
module tb_cache_tag_lru;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] lookup_address;
    logic [3:0] line_select;
    logic       cache_write_enable;
    logic       set_valid_bit;
    logic       set_dirty_bit;
    logic       clear_dirty_bit;
    logic       hit_signal;
    logic       invalidate_all;
    logic       cache_hit;
    logic [3:0] hit_lines;
    logic [1:0] hit_index;
    logic [1:0] replace_index;
    logic       replace_dirty;
    logic [7:0] replace_tag;
    logic [3:0] valid_bits;
    logic [3:0] dirty_bits;
    logic       sel_error;

    int n_cmp = 0;
    int n_bad = 0;

    cache_tag_lru #(.CACHE_SIZE(4), .ADDR_WIDTH(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .lookup_address     (lookup_address),
        .line_select        (line_select),
        .cache_write_enable (cache_write_enable),
        .set_valid_bit      (set_valid_bit),
        .set_dirty_bit      (set_dirty_bit),
        .clear_dirty_bit    (clear_dirty_bit),
        .hit_signal         (hit_signal),
        .invalidate_all     (invalidate_all),
        .cache_hit          (cache_hit),
        .hit_lines          (hit_lines),
        .hit_index          (hit_index),
        .replace_index      (replace_index),
        .replace_dirty      (replace_dirty),
        .replace_tag        (replace_tag),
        .valid_bits         (valid_bits),
        .dirty_bits         (dirty_bits),
        .sel_error          (sel_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        line_select        = 4'b0000;
        cache_write_enable = 1'b0;
        set_valid_bit      = 1'b0;
        set_dirty_bit      = 1'b0;
        clear_dirty_bit    = 1'b0;
        hit_signal         = 1'b0;
        invalidate_all     = 1'b0;
    endtask

    task automatic fill(input int k, input logic [7:0] addr, input logic d);
        lookup_address     = addr;
        line_select        = 4'(1 << k);
        cache_write_enable = 1'b1;
        set_valid_bit      = 1'b1;
        set_dirty_bit      = d;
        tick();
        idle();
    endtask

    task automatic touch(input int k);
        line_select = 4'(1 << k);
        hit_signal  = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        reset          = 1'b1;
        lookup_address = 8'h00;
        idle();
        #1;
        chk("rst_hit",    32'(cache_hit), 32'h0);
        chk("rst_valid",  32'(valid_bits), 32'h0);
        chk("rst_selerr", 32'(sel_error), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("idle_hit",     32'(cache_hit), 32'h0);
        chk("idle_replace", 32'(replace_index), 32'h0);
        chk("idle_valid",   32'(valid_bits), 32'h0);
        chk("idle_selerr",  32'(sel_error), 32'h0);

        // Fill 0..3 in order: ages become 3,2,1,0
        fill(0, 8'h10, 1'b0);
        fill(1, 8'h20, 1'b0);
        fill(2, 8'h30, 1'b0);
        fill(3, 8'h40, 1'b0);
        chk("fill_valid", 32'(valid_bits), 32'hF);
        chk("fill_dirty", 32'(dirty_bits), 32'h0);
        lookup_address = 8'h30;
        tick();
        chk("lk30_hit",     32'(cache_hit), 32'h1);
        chk("lk30_lines",   32'(hit_lines), 32'h4);
        chk("lk30_index",   32'(hit_index), 32'h2);
        chk("lk30_replace", 32'(replace_index), 32'h0);
        chk("lk30_rtag",    32'(replace_tag), 32'h10);

        // Touch 0 -> ages 0,3,2,1; touch 1 -> ages 1,0,3,2
        touch(0);
        tick();
        chk("touch0_replace", 32'(replace_index), 32'h1);
        touch(1);
        tick();
        chk("touch1_replace", 32'(replace_index), 32'h2);

        // Dirty fill of line 2 (ages 2,1,0,3), then touch 3,0,1 -> ages 1,0,3,2
        fill(2, 8'h55, 1'b1);
        chk("wfill_dirty", 32'(dirty_bits), 32'h4);
        touch(3);
        touch(0);
        touch(1);
        tick();
        chk("lru2_replace", 32'(replace_index), 32'h2);
        chk("lru2_rdirty",  32'(replace_dirty), 32'h1);
        chk("lru2_rtag",    32'(replace_tag), 32'h55);
        chk("lk55_index",   32'(hit_index), 32'h2);

        // Clear dirty on line 2; it is also touched -> ages 2,1,0,3
        line_select        = 4'b0100;
        cache_write_enable = 1'b1;
        clear_dirty_bit    = 1'b1;
        tick();
        idle();
        chk("clr_dirty_bits", 32'(dirty_bits), 32'h0);
        chk("clr_rdirty_old", 32'(replace_dirty), 32'h1);
        tick();
        chk("clr_rdirty_new", 32'(replace_dirty), 32'h0);
        chk("clr_replace",    32'(replace_index), 32'h3);
        chk("clr_rtag",       32'(replace_tag), 32'h40);

        // Non-one-hot fill is dropped and flags a sticky error
        lookup_address     = 8'h99;
        line_select        = 4'b0011;
        cache_write_enable = 1'b1;
        set_valid_bit      = 1'b1;
        tick();
        idle();
        chk("bad_selerr", 32'(sel_error), 32'h1);
        chk("bad_valid",  32'(valid_bits), 32'hF);
        tick();
        chk("bad_hit",     32'(cache_hit), 32'h0);
        chk("bad_replace", 32'(replace_index), 32'h3);
        chk("bad_rtag",    32'(replace_tag), 32'h40);
        tick();
        chk("bad_sticky", 32'(sel_error), 32'h1);

        // Flush with a same-cycle fill: fill must be dropped
        lookup_address     = 8'h77;
        line_select        = 4'b0010;
        cache_write_enable = 1'b1;
        set_valid_bit      = 1'b1;
        invalidate_all     = 1'b1;
        tick();
        idle();
        chk("inv_valid", 32'(valid_bits), 32'h0);
        chk("inv_dirty", 32'(dirty_bits), 32'h0);
        tick();
        chk("inv_hit",     32'(cache_hit), 32'h0);
        chk("inv_replace", 32'(replace_index), 32'h0);
        chk("inv_rtag",    32'(replace_tag), 32'h10);

        // Reset between a fill and its lookup
        fill(1, 8'h66, 1'b0);
        chk("pre_rst_valid", 32'(valid_bits), 32'h2);
        reset = 1'b1;
        #1;
        chk("arst_valid",  32'(valid_bits), 32'h0);
        chk("arst_selerr", 32'(sel_error), 32'h0);
        chk("arst_rtag",   32'(replace_tag), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_hit",   32'(cache_hit), 32'h0);
        chk("post_rst_lines", 32'(hit_lines), 32'h0);
        chk("post_rst_repl",  32'(replace_index), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_tag_lru.md
# cache_tag_lru

Tag store and replacement unit for the 4-line fully-associative cache, directly upstream of the cache control FSM. It holds one tag plus valid and dirty bits per line, and tracks true-LRU order with 2-bit age counters. Each cycle it registers the hit/miss result for the FSM's current address and the victim line to use on a miss. It applies the FSM's fill, dirty and touch commands on the next clock edge.

## Interface
- CACHE_SIZE, 4, number of lines; only 4 is supported (indices are 2 bits)
- ADDR_WIDTH, 8, address width; the full address is the tag (BLOCK_SIZE = 1)
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- lookup_address  input  ADDR_WIDTH  address under comparison (the FSM's current_address)
- line_select  input  CACHE_SIZE  one-hot target line for a command
- cache_write_enable  input  1  command strobe for fill or write
- set_valid_bit  input  1  fill: load tag and set valid
- set_dirty_bit  input  1  set dirty on the selected line
- clear_dirty_bit  input  1  clear dirty on the selected line
- hit_signal  input  1  access strobe; touches the selected line for LRU
- invalidate_all  input  1  synchronous flush of all valid and dirty bits
- cache_hit  output  1  registered: some valid tag equals lookup_address
- hit_lines  output  CACHE_SIZE  registered per-line match vector
- hit_index  output  2  registered index of the lowest set bit of hit_lines
- replace_index  output  2  registered victim line
- replace_dirty  output  1  registered dirty bit of the victim
- replace_tag  output  ADDR_WIDTH  registered tag of the victim
- valid_bits  output  CACHE_SIZE  current valid bits
- dirty_bits  output  CACHE_SIZE  current dirty bits
- sel_error  output  1  sticky; set on any command with a non-one-hot line_select

## Operation
- Per-line state: tag[ADDR_WIDTH], valid, dirty, age[2]. Age 0 = MRU, age 3 = LRU; the ages always form a permutation of 0..3.
- Reset (async) values:
  - tags = 0, valid = 0, dirty = 0, ages = {line0:0, line1:1, line2:2, line3:3}.
  - All registered outputs = 0, sel_error = 0.
- Lookup, every cycle:
  - hit_lines[i] <= valid[i] && tag[i] == lookup_address, computed from pre-edge state.
  - cache_hit <= |match; hit_index <= lowest matching index, or 0 if there is no match.
- Victim selection, every cycle:
  - replace_index <= lowest-index invalid line if any exists, else the line with age == 3.
  - replace_dirty and replace_tag are taken from that line, using pre-edge state.
- Command is legal when line_select is exactly one-hot. Any strobe (cache_write_enable, hit_signal, set_dirty_bit, clear_dirty_bit) with an illegal select:
  - no state change;
  - sel_error <= 1.
- Fill, when cache_write_enable && set_valid_bit:
  - tag[k] <= lookup_address, valid[k] <= 1;
  - dirty[k] <= set_dirty_bit (write-allocate fill is dirty, read fill is clean).
- When cache_write_enable && !set_valid_bit:
  - set_dirty_bit sets dirty[k];
  - else clear_dirty_bit clears dirty[k].
  - Set wins over clear.
- Touch, when (hit_signal || cache_write_enable) with a legal select on line k:
  - every line with age < age[k] increments;
  - age[k] <= 0;
  - all other lines are unchanged.
- invalidate_all clears all valid and dirty bits and leaves tags and ages unchanged. It has priority over any same-cycle command; that command is dropped, including its touch.

## Timing
- Lookup latency is 1 cycle: outputs at edge N+1 reflect lookup_address as it stood before edge N+1.
  - This fits the FSM, which samples cache_hit on its second TAG_COMPARE cycle.
- A command presented before edge N updates state at edge N.
  - Lookup and victim outputs registered at edge N use the old state.
  - The new state is visible at edge N+1.
- valid_bits and dirty_bits are driven directly from state, i.e. they update at the command edge.
- A reset assertion mid-operation immediately returns all state and outputs to their reset values. There is no partial update.

## Test plan
- Reset, then hold lookup_address = 0x00 -> cache_hit = 0, replace_index = 0, valid_bits = 0000, sel_error = 0.
- Fill lines 0–3 with 0x10, 0x20, 0x30, 0x40 (clean), then look up 0x30 -> cache_hit = 1, hit_lines = 0100, hit_index = 2; replace_index = 0 (ages 3,2,1,0).
- After the previous step, touch line 0 with hit_signal -> replace_index = 1; then touch line 1 -> replace_index = 2.
- Write-fill line 2 with set_dirty_bit, then make it the LRU line -> replace_dirty = 1, replace_tag = that line's address; clear_dirty_bit on line 2 -> replace_dirty = 0 on the next edge.
- cache_write_enable with line_select = 0011 -> no tag, valid or age change, sel_error = 1 until reset; invalidate_all -> valid_bits = 0000, replace_index = 0.
- Assert reset between a fill command and the following lookup -> cache_hit = 0 and ages return to {0,1,2,3}.
